// File: rtl/sys_ctrl.sv
// UART command sequencer: decodes write/read frames into REG_FILE
// accesses and returns read data as a single transmit byte.
module sys_ctrl #(
    parameter int                DATA_W = 8,
    parameter int                ADD_W  = 4,
    parameter logic [DATA_W-1:0] WR_CMD = 8'hAA,
    parameter logic [DATA_W-1:0] RD_CMD = 8'hBB,
    parameter int                TO_CYC = 4
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_Data,
    input  logic              RX_D_VLD,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdData_Valid,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADD_W-1:0]  Address,
    output logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] TX_P_Data,
    output logic              TX_D_VLD,
    input  logic              TX_Busy,
    output logic              Frame_Err
);

    localparam int CNT_W = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TO_CYC);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              wr_en_d;
    logic              rd_en_d;
    logic              tx_vld_d;
    logic              ferr_d;
    logic [ADD_W-1:0]  addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] tx_data_d;

    // State, timeout counter and every output are registered here.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_Data <= '0;
            TX_D_VLD  <= 1'b0;
            Frame_Err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            WrEn      <= wr_en_d;
            RdEn      <= rd_en_d;
            Address   <= addr_d;
            WrData    <= wdata_d;
            TX_P_Data <= tx_data_d;
            TX_D_VLD  <= tx_vld_d;
            Frame_Err <= ferr_d;
        end
    end

    // Frame decode: next state and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        ferr_d    = 1'b0;
        addr_d    = Address;
        wdata_d   = WrData;
        tx_data_d = TX_P_Data;
        unique case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_Data == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_Data == RD_CMD) begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_Data[ADD_W-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_Data;
                    wr_en_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_Data[ADD_W-1:0];
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A byte arriving mid-read cannot be queued; flag it.
                ferr_d = RX_D_VLD;
                if (RdData_Valid) begin
                    tx_data_d = RdData;
                    state_d   = TX_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TO_CNT) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            TX_SEND: begin
                ferr_d = RX_D_VLD;
                if (!TX_Busy) begin
                    tx_vld_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: directed frames then random traffic,
// checked each cycle against a frame-level reference model.
module tb_sys_ctrl;

    logic       Clk = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_Data = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] TX_P_Data;
    logic       TX_D_VLD;
    logic       TX_Busy = 1'b0;
    logic       Frame_Err;

    int n_cmp = 0;
    int n_err = 0;
    bit rf_resp = 1'b1;

    sys_ctrl dut (
        .Clk          (Clk),
        .RST          (RST),
        .RX_P_Data    (RX_P_Data),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .TX_P_Data    (TX_P_Data),
        .TX_D_VLD     (TX_D_VLD),
        .TX_Busy      (TX_Busy),
        .Frame_Err    (Frame_Err)
    );

    always #5 Clk = ~Clk;

    // Attached register file: data valid one cycle after RdEn.
    logic [7:0] rf_mem [16];
    always @(posedge Clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
            rf_mem[2]    <= 8'h81;
            rf_mem[3]    <= 8'h20;
            RdData       <= 8'h00;
            RdData_Valid <= 1'b0;
        end else begin
            if (WrEn) rf_mem[Address] <= WrData;
            if (RdEn) RdData <= rf_mem[Address];
            RdData_Valid <= RdEn && rf_resp;
        end
    end

    // Reference model: frame bytes collected so far plus read progress.
    logic [7:0] fr_q [$];
    logic [7:0] m_mem [16];
    bit         waiting;
    int         wait_cnt;
    bit         tx_hold;
    logic       e_wren, e_rden, e_txv, e_ferr;
    logic [3:0] e_addr;
    logic [7:0] e_wdata, e_tx;

    task automatic model_reset();
        fr_q.delete();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_mem[2] = 8'h81;
        m_mem[3] = 8'h20;
        waiting  = 0;
        wait_cnt = 0;
        tx_hold  = 0;
        e_wren   = 0;
        e_rden   = 0;
        e_txv    = 0;
        e_ferr   = 0;
        e_addr   = '0;
        e_wdata  = '0;
        e_tx     = '0;
    endtask

    task automatic model_edge(input logic vld, input logic [7:0] b,
                              input logic busy, input logic rdv);
        e_wren = 0;
        e_rden = 0;
        e_txv  = 0;
        e_ferr = 0;
        if (tx_hold) begin
            if (vld) e_ferr = 1;
            if (!busy) begin
                e_txv   = 1;
                tx_hold = 0;
            end
        end else if (waiting) begin
            if (vld) e_ferr = 1;
            if (rdv) begin
                e_tx    = m_mem[e_addr];
                tx_hold = 1;
                waiting = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt == 4) begin
                    e_ferr  = 1;
                    waiting = 0;
                end
            end
        end else if (vld) begin
            if (fr_q.size() == 0) begin
                if (b == 8'hAA || b == 8'hBB) fr_q.push_back(b);
            end else if (fr_q[0] == 8'hBB) begin
                e_addr   = b[3:0];
                e_rden   = 1;
                waiting  = 1;
                wait_cnt = 0;
                fr_q.delete();
            end else if (fr_q.size() == 1) begin
                e_addr = b[3:0];
                fr_q.push_back(b);
            end else begin
                e_wdata        = b;
                e_wren         = 1;
                m_mem[e_addr]  = b;
                fr_q.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("WrEn", {7'd0, WrEn}, {7'd0, e_wren});
        chk("RdEn", {7'd0, RdEn}, {7'd0, e_rden});
        chk("Address", {4'd0, Address}, {4'd0, e_addr});
        chk("WrData", WrData, e_wdata);
        chk("TX_P_Data", TX_P_Data, e_tx);
        chk("TX_D_VLD", {7'd0, TX_D_VLD}, {7'd0, e_txv});
        chk("Frame_Err", {7'd0, Frame_Err}, {7'd0, e_ferr});
        chk("excl", {7'd0, WrEn & RdEn}, 8'h00);
    endtask

    task automatic step(input logic vld, input logic [7:0] b);
        logic rdv;
        RX_D_VLD  = vld;
        RX_P_Data = b;
        rdv = RdData_Valid;
        @(posedge Clk);
        model_edge(vld, b, TX_Busy, rdv);
        #1;
        check_all();
    endtask

    task automatic rx(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        RX_D_VLD = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge Clk);
        #1;
        check_all();
        RST = 1'b0;
    endtask

    initial begin
        // 1: write then read back
        @(posedge Clk);
        #1;
        do_reset();
        rx(8'hAA); rx(8'h05); rx(8'h3C);
        idle(2);
        rx(8'hBB); rx(8'h05);
        idle(6);
        chk("t1_tx", TX_P_Data, 8'h3C);

        // 2: reset values of the register file
        do_reset();
        rx(8'hBB); rx(8'h02);
        idle(6);
        chk("t2_tx81", TX_P_Data, 8'h81);
        rx(8'hBB); rx(8'h03);
        idle(6);
        chk("t2_tx20", TX_P_Data, 8'h20);

        // 3: junk byte ignored, then write to F
        rx(8'h12);
        rx(8'hAA); rx(8'h0F); rx(8'h55);
        idle(2);
        chk("t3_wdata", WrData, 8'h55);

        // 4: transmitter busy during a read, stray byte
        TX_Busy = 1'b1;
        rx(8'hBB); rx(8'h02);
        idle(3);
        rx(8'h33);
        idle(6);
        TX_Busy = 1'b0;
        idle(3);

        // 5: read timeout
        rf_resp = 1'b0;
        rx(8'hBB); rx(8'h01);
        idle(8);
        rf_resp = 1'b1;

        // 6: reset mid-frame, then a clean write
        rx(8'hAA); rx(8'h07);
        do_reset();
        rx(8'hAA); rx(8'h07); rx(8'h99);
        idle(2);
        chk("t6_addr", {4'd0, Address}, 8'h07);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic       v;
            logic [7:0] b;
            int         r;
            v = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 5);
            if (r < 2) b = 8'hAA;
            else if (r == 2) b = 8'hBB;
            else b = 8'($urandom);
            TX_Busy = ($urandom_range(0, 2) == 0);
            rf_resp = ($urandom_range(0, 7) != 0);
            step(v, b);
            if (i == 2000) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
